// File: rtl/mic1_uart_tx_if.sv
// Byte handshake between the mic-1 SoC output path and the UART transmitter.
// The producer holds in_data and in_valid until it sees in_ready high at a clock edge.
interface mic1_uart_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/mic1_uart_tx.sv
// Buffered 8N1 UART transmitter for the board TX pin.
// Bytes enter a small circular FIFO. A four-state FSM pops them and shifts
// them out LSB-first. Each serial bit lasts CLKS_PER_BIT clock cycles.
module mic1_uart_tx #(
  parameter int CLKS_PER_BIT = 52,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  mic1_uart_tx_if.slave                 bus,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // FIFO storage and pointers. Each pointer has one extra wrap bit, so full
  // and empty can be told apart.
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

  // Serialiser state.
  state_e        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic [AW:0]   w_level;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_baud_end;
  logic [7:0]    w_head;

  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (w_level == FULL_LEVEL);
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: in_ready looks only at the registered FIFO state. A pop in the same
  // cycle does not make a full FIFO ready, which keeps this path free of any
  // combinational loop through the FSM.
  assign bus.in_ready = !w_full;
  assign w_push       = bus.in_valid && !w_full;

  // The FSM takes the head byte in IDLE, or at the end of a stop bit, if the FIFO holds data.
  assign w_pop = !w_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));

  assign tx         = r_tx;
  assign fifo_level = w_level;
  assign busy       = (r_state != S_IDLE) || (w_level != '0);

  // Write a pushed byte into its FIFO slot.
  // NOTE: the storage array has no reset. The pointers alone decide which
  // entries are valid, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
    end
  end

  // Advance the FIFO pointers. They wrap naturally modulo twice the depth.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the values from before the clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Frame FSM: start bit, 8 data bits LSB-first, stop bit; tx is registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_tx    <= 1'b0;
            r_baud  <= '0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              // Start the next frame right away, with no idle gap.
              r_shift <= w_head;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_baud  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mic1_uart_tx.sv
// Self-checking bench for mic1_uart_tx.
// dut4 uses a short bit time for the functional scenarios.
// dut52 uses the production bit time for the baud check.
// Expected serial waveforms come from an 8N1 frame model: bit index 0 is the
// start bit, indices 1..8 are the data bits LSB-first, and index 9 is the stop bit.
module tb_mic1_uart_tx;

  localparam int CPB      = 4;
  localparam int CPB_SLOW = 52;
  localparam int FRAME    = 10 * CPB;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mic1_uart_tx_if bus4 ();
  mic1_uart_tx_if bus52 ();

  logic       tx4, busy4, tx52, busy52;
  logic [2:0] lvl4, lvl52;

  mic1_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .resetn(resetn), .bus(bus4),
    .tx(tx4), .busy(busy4), .fifo_level(lvl4)
  );

  mic1_uart_tx #(.CLKS_PER_BIT(CPB_SLOW), .FIFO_DEPTH(4)) dut52 (
    .clk(clk), .resetn(resetn), .bus(bus52),
    .tx(tx52), .busy(busy52), .fifo_level(lvl52)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         peak_lvl = 0;
  logic [7:0] exp_q[$];

  // Advance one cycle. Sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference 8N1 line level for bit index idx of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx <= 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return ((int'(b) >> (idx - 1)) % 2) == 1;
  endfunction

  // Offer one byte to dut4 and hold it until accepted; then scramble in_data.
  task automatic push_byte(input logic [7:0] b, input int max_wait, output bit ok);
    bit rdy;
    ok = 1'b0;
    bus4.in_data  = b;
    bus4.in_valid = 1'b1;
    for (int w = 0; w < max_wait; w++) begin
      rdy = bus4.in_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    bus4.in_valid = 1'b0;
    bus4.in_data  = 8'($urandom);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL push_timeout byte=%02h: not accepted within %0d cycles", b, max_wait);
    end
  endtask

  // Wait a bounded number of cycles for tx4 to fall (start of a frame).
  task automatic wait_fall(input int max_wait, output bit ok);
    ok = 1'b0;
    for (int w = 0; w < max_wait; w++) begin
      tick();
      if (tx4 === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL start_timeout: tx stayed high for %0d cycles", max_wait);
    end
  endtask

  // Starting at the first start-bit cycle, compare every cycle of the frame.
  task automatic check_body(input logic [7:0] b);
    logic exp_bit;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) tick();
      if (int'(lvl4) > peak_lvl) peak_lvl = int'(lvl4);
      exp_bit = frame_bit(b, k / CPB);
      n_vec++;
      if (tx4 !== exp_bit) begin
        n_err++;
        $display("FAIL frame_bit byte=%02h cycle=%0d: tx=%b expected %b", b, k, tx4, exp_bit);
      end
    end
  endtask

  task automatic expect_frame(input logic [7:0] b, input int max_wait);
    bit ok;
    wait_fall(max_wait, ok);
    if (ok) check_body(b);
  endtask

  task automatic test_reset();
    bus4.in_valid  = 1'b1;
    bus4.in_data   = 8'hA5;
    bus52.in_valid = 1'b0;
    bus52.in_data  = 8'h00;
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (tx4 !== 1'b1 || lvl4 !== 3'd0 || busy4 !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d: tx=%b lvl=%0d busy=%b expected 1/0/0", i, tx4, lvl4, busy4);
      end
    end
    bus4.in_valid = 1'b0;
    resetn = 1'b1;
    tick();
    n_vec++;
    if (tx4 !== 1'b1 || lvl4 !== 3'd0 || busy4 !== 1'b0 || bus4.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: tx=%b lvl=%0d busy=%b ready=%b expected 1/0/0/1",
               tx4, lvl4, busy4, bus4.in_ready);
    end
  endtask

  task automatic test_single();
    bit ok;
    push_byte(8'hA5, 2, ok);
    n_vec++;
    if (tx4 !== 1'b1 || lvl4 !== 3'd1 || busy4 !== 1'b1) begin
      n_err++;
      $display("FAIL single_after_push: tx=%b lvl=%0d busy=%b expected 1/1/1", tx4, lvl4, busy4);
    end
    // tx must go low after the very next edge.
    expect_frame(8'hA5, 1);
    n_vec++;
    if (busy4 !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy_in_stop: busy=%b expected 1", busy4);
    end
    tick();
    n_vec++;
    if (busy4 !== 1'b0 || tx4 !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy_drop: busy=%b tx=%b expected 0/1", busy4, tx4);
    end
  endtask

  task automatic test_back_to_back();
    peak_lvl = 0;
    fork
      begin
        bit ok;
        push_byte(8'h00, 2, ok);
        push_byte(8'hFF, 2, ok);
        push_byte(8'h55, 2, ok);
      end
      begin
        expect_frame(8'h00, 4);
        expect_frame(8'hFF, 1);
        expect_frame(8'h55, 1);
      end
    join
    n_vec++;
    if (peak_lvl != 2) begin
      n_err++;
      $display("FAIL b2b_peak_level: peak=%0d expected 2", peak_lvl);
    end
    tick();
    n_vec++;
    if (busy4 !== 1'b0 || lvl4 !== 3'd0) begin
      n_err++;
      $display("FAIL b2b_idle: busy=%b lvl=%0d expected 0/0", busy4, lvl4);
    end
  endtask

  task automatic test_full_fifo();
    int first_cyc;
    int acc_cyc;
    fork
      begin
        bit ok;
        bit rdy;
        bit seen_lvl3;
        for (int i = 1; i <= 5; i++) begin
          push_byte(8'(i), 2, ok);
          if (i == 1) first_cyc = cyc;
        end
        // Five accepted, one already popped into the shifter.
        n_vec++;
        if (lvl4 !== 3'd4 || bus4.in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL full_level: lvl=%0d ready=%b expected 4/0", lvl4, bus4.in_ready);
        end
        bus4.in_data  = 8'd6;
        bus4.in_valid = 1'b1;
        acc_cyc   = -1;
        seen_lvl3 = 1'b0;
        for (int w = 0; w < 100; w++) begin
          rdy = bus4.in_ready;
          if (lvl4 === 3'd4 && rdy !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL full_ready: ready=%b while level=4", rdy);
          end
          seen_lvl3 = (lvl4 === 3'd3);
          tick();
          if (rdy) begin
            acc_cyc = cyc;
            break;
          end
        end
        bus4.in_valid = 1'b0;
        // The first pop after filling ends frame 1; the 6th byte goes in one edge later.
        n_vec++;
        if (acc_cyc != first_cyc + 2 + FRAME || !seen_lvl3) begin
          n_err++;
          $display("FAIL full_sixth_accept: at cycle %0d (lvl3 seen=%b) expected %0d",
                   acc_cyc - first_cyc, seen_lvl3, 2 + FRAME);
        end
      end
      begin
        expect_frame(8'd1, 4);
        for (int i = 2; i <= 6; i++) expect_frame(8'(i), 1);
      end
    join
    tick();
    n_vec++;
    if (busy4 !== 1'b0 || lvl4 !== 3'd0) begin
      n_err++;
      $display("FAIL full_idle: busy=%b lvl=%0d expected 0/0", busy4, lvl4);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int glitches;
    push_byte(8'h0F, 2, ok);
    push_byte(8'h33, 2, ok);
    wait_fall(4, ok);
    // Move to the second cycle of data bit 3 (frame bit index 4).
    for (int k = 0; k < 4 * CPB + 1; k++) tick();
    n_vec++;
    if (tx4 !== frame_bit(8'h0F, 4)) begin
      n_err++;
      $display("FAIL mid_bit3_level: tx=%b expected %b", tx4, frame_bit(8'h0F, 4));
    end
    #2 resetn = 1'b0;
    #1;
    n_vec++;
    if (tx4 !== 1'b1 || lvl4 !== 3'd0 || busy4 !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async_reset: tx=%b lvl=%0d busy=%b expected 1/0/0", tx4, lvl4, busy4);
    end
    tick();
    tick();
    resetn = 1'b1;
    tick();
    push_byte(8'h81, 2, ok);
    expect_frame(8'h81, 1);
    // The aborted 0x33 must never appear.
    glitches = 0;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (tx4 !== 1'b1) glitches++;
    end
    n_vec++;
    if (glitches != 0 || busy4 !== 1'b0) begin
      n_err++;
      $display("FAIL mid_post_idle: %0d low cycles busy=%b expected 0/0", glitches, busy4);
    end
    // Abort while tx is low in a start bit: the line must rise without a clock edge.
    push_byte(8'hC3, 2, ok);
    wait_fall(4, ok);
    tick();
    #2 resetn = 1'b0;
    #1;
    n_vec++;
    if (tx4 !== 1'b1) begin
      n_err++;
      $display("FAIL start_async_reset: tx=%b expected 1", tx4);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_random();
    exp_q.delete();
    fork
      begin
        bit ok;
        int gap;
        logic [7:0] b;
        for (int i = 0; i < 24; i++) begin
          gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60))
                                            : int'($urandom_range(0, 2));
          repeat (gap) tick();
          b = 8'($urandom);
          push_byte(b, 200, ok);
          if (ok) exp_q.push_back(b);
        end
      end
      begin
        bit ok;
        logic [7:0] b;
        for (int i = 0; i < 24; i++) begin
          wait_fall(300, ok);
          if (!ok) break;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rand_unexpected_frame: frame %0d with empty model queue", i);
          end else begin
            b = exp_q.pop_front();
            check_body(b);
          end
        end
      end
    join
    tick();
    n_vec++;
    if (busy4 !== 1'b0 || lvl4 !== 3'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: busy=%b lvl=%0d left=%0d expected 0/0/0", busy4, lvl4, exp_q.size());
    end
  endtask

  task automatic test_baud();
    bit   found;
    logic prev;
    int   n_edges;
    int   exp_edges;
    exp_edges = 0;
    for (int i = 1; i < 10; i++)
      if (frame_bit(8'h55, i) != frame_bit(8'h55, i - 1)) exp_edges++;
    bus52.in_data  = 8'h55;
    bus52.in_valid = 1'b1;
    tick();
    bus52.in_valid = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 4; w++) begin
      tick();
      if (tx52 === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL baud_start_timeout: tx52 never fell");
    end else begin
      prev    = 1'b0;
      n_edges = 0;
      for (int c = 0; c <= 10 * CPB_SLOW; c++) begin
        if (c > 0) tick();
        if (c < 10 * CPB_SLOW) begin
          n_vec++;
          if (tx52 !== frame_bit(8'h55, c / CPB_SLOW)) begin
            n_err++;
            $display("FAIL baud_bit cycle=%0d: tx=%b expected %b", c, tx52, frame_bit(8'h55, c / CPB_SLOW));
          end
        end
        if (tx52 !== prev) begin
          n_edges++;
          n_vec++;
          if (c % CPB_SLOW != 0) begin
            n_err++;
            $display("FAIL baud_edge_spacing: edge at cycle %0d not a multiple of %0d", c, CPB_SLOW);
          end
        end
        prev = tx52;
      end
      n_vec++;
      if (n_edges != exp_edges || busy52 !== 1'b0 || tx52 !== 1'b1) begin
        n_err++;
        $display("FAIL baud_frame_end: edges=%0d busy=%b tx=%b expected %0d/0/1",
                 n_edges, busy52, tx52, exp_edges);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_fifo();
    test_reset_mid_frame();
    test_random();
    test_baud();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
